no_border_ctrl_unit: RTL and testbench

- Control unit directly upstream of no_border_scheme_mask.
- Accepts a raster-order pixel stream over a valid/ready handshake and registers each accepted pixel onto data_cu2bufcf / ctrl2buf_valid.
- Tracks row/column position within the frame and generates a window-valid strobe, aligned to the mask output, only when the 7x7 window lies fully inside the image (no-border scheme).
- Signals end of frame to downstream.

---
 rtl/no_border_ctrl_unit.sv | 233 +++++++++++++++++++++++
 tb/tb_no_border_ctrl_unit.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/no_border_ctrl_unit.sv
// no_border_ctrl_unit
// Control unit that sits directly in front of no_border_scheme_mask.
// It takes a raster-order pixel stream over a valid/ready handshake and
// registers each accepted pixel towards the row buffers. It also tracks the
// frame position and flags, in step with the mask output, the windows whose
// 7x7 footprint lies fully inside the image. A one-cycle pulse marks the end
// of each frame.
//
// Optional build feature: define NO_BORDER_FRAME_CHK_EN to enable frame
// protocol checking. A sof during a frame then restarts the frame and sets a
// sticky frame_err. A pixel offered while draining also sets frame_err.
// Without the macro, frame_err is tied low and a mid-frame sof is ignored.

module no_border_ctrl_unit #(
  parameter int ROW_WIDTH  = 100,  // pixels per row
  parameter int COL_HEIGHT = 100,  // rows per frame
  parameter int PIX_BIT    = 8,    // bits per pixel
  parameter int MASK_WIDTH = 7,    // mask width/height
  parameter int MASK_LAT   = 1     // ctrl2buf_valid -> updated window on p_m2f
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sof,
  input  logic               pix_in_valid,
  input  logic [PIX_BIT-1:0] pix_in,
  output logic               pix_in_ready,
  input  logic               filt_stall,
  output logic               ctrl2buf_valid,
  output logic [PIX_BIT-1:0] data_cu2bufcf,
  output logic               win_valid,
  output logic [15:0]        win_row,
  output logic [15:0]        win_col,
  output logic               frame_done,
  output logic               frame_err
);

  // Frame geometry as 16-bit constants, so they compare cleanly with the counters.
  localparam logic [15:0] LAST_COL   = 16'(ROW_WIDTH - 1);
  localparam logic [15:0] LAST_ROW   = 16'(COL_HEIGHT - 1);
  localparam logic [15:0] EDGE_OFS   = 16'(MASK_WIDTH - 1);
  localparam logic [15:0] HALF_MASK  = 16'((MASK_WIDTH - 1) / 2);
  localparam logic [15:0] DRAIN_LAST = 16'(MASK_LAT);
  localparam int          DEPTH      = MASK_LAT + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DRAIN  = 2'd2
  } state_t;

  // One delay-line entry: window qualifier plus the window centre.
  typedef struct packed {
    logic        vld;
    logic [15:0] row;
    logic [15:0] col;
  } win_t;

  state_t             state_q, state_d;
  logic [15:0]        row_q, row_d;
  logic [15:0]        col_q, col_d;
  logic [15:0]        drain_q, drain_d;
  logic               frame_done_q, frame_done_d;
  logic               c2b_valid_q;
  logic [PIX_BIT-1:0] data_q;
  win_t               dly_q [DEPTH];
  win_t               stage_in;
  logic               accept;
  logic               restart;
  logic               flush;
  logic               in_img;

`ifdef NO_BORDER_FRAME_CHK_EN
  logic               frame_err_q, frame_err_d;

  // A sof while a frame is in progress restarts it.
  assign restart = sof & (state_q != IDLE);
`else
  assign restart = 1'b0;
`endif

  // Ready follows filt_stall combinationally. No pixel is taken in a restart cycle.
  assign pix_in_ready = (state_q == ACTIVE) & ~filt_stall & ~restart;
  assign accept       = pix_in_valid & pix_in_ready;

  // Next state, frame position counters and the drain timer.
  always_comb begin
    // NOTE: every variable gets a default before the case, so no path can
    // leave one unassigned and infer a latch.
    state_d      = state_q;
    row_d        = row_q;
    col_d        = col_q;
    drain_d      = drain_q;
    frame_done_d = 1'b0;
    flush        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (sof) begin
          state_d = ACTIVE;
          row_d   = '0;
          col_d   = '0;
          drain_d = '0;
        end
      end
      ACTIVE: begin
        if (accept) begin
          if (col_q == LAST_COL) begin
            col_d = '0;
            if (row_q == LAST_ROW) begin
              // The last pixel of the frame has been taken. Let the windows drain.
              row_d   = '0;
              drain_d = '0;
              state_d = DRAIN;
            end else begin
              row_d = row_q + 16'd1;
            end
          end else begin
            col_d = col_q + 16'd1;
          end
        end
      end
      DRAIN: begin
        // The last window leaves the delay line after MASK_LAT+1 cycles.
        if (drain_q == DRAIN_LAST) begin
          frame_done_d = 1'b1;
          drain_d      = '0;
          state_d      = IDLE;
        end else begin
          drain_d = drain_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (restart) begin
      state_d      = ACTIVE;
      row_d        = '0;
      col_d        = '0;
      drain_d      = '0;
      frame_done_d = 1'b0;
      flush        = 1'b1;
    end
  end

  // State register, counters and the registered frame_done pulse.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments only. All registers
    // then update together at the edge, whatever order the statements are in.
    if (reset) begin
      state_q      <= IDLE;
      row_q        <= '0;
      col_q        <= '0;
      drain_q      <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      col_q        <= col_d;
      drain_q      <= drain_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Pixel register towards the row buffers. The data holds when nothing is accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      c2b_valid_q <= 1'b0;
      data_q      <= '0;
    end else begin
      c2b_valid_q <= accept;
      if (accept) begin
        data_q <= pix_in;
      end
    end
  end

  // Qualify the window whose bottom-right corner is the pixel being accepted.
  always_comb begin
    in_img   = (row_q >= EDGE_OFS) && (col_q >= EDGE_OFS);
    stage_in = '0;
    if (accept && in_img) begin
      stage_in.vld = 1'b1;
      stage_in.row = row_q - HALF_MASK;
      stage_in.col = col_q - HALF_MASK;
    end
  end

  // Delay line that aligns the window qualifier with the mask output.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: this small array is reset explicitly, so that no stale window can
    // appear after reset. Large data memories would normally be left unreset.
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        dly_q[i] <= '0;
      end
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        dly_q[i] <= '0;
      end
    end else begin
      dly_q[0] <= stage_in;
      for (int i = 1; i < DEPTH; i++) begin
        dly_q[i] <= dly_q[i-1];
      end
    end
  end

`ifdef NO_BORDER_FRAME_CHK_EN
  // The error flag is sticky until reset. It is set by a mid-frame sof or by a pixel offered during drain.
  always_comb begin
    frame_err_d = frame_err_q | restart | ((state_q == DRAIN) & pix_in_valid);
  end

  // Error flag register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= frame_err_d;
    end
  end

  assign frame_err = frame_err_q;
`else
  assign frame_err = 1'b0;
`endif

  assign ctrl2buf_valid = c2b_valid_q;
  assign data_cu2bufcf  = data_q;
  assign win_valid      = dly_q[DEPTH-1].vld;
  assign win_row        = dly_q[DEPTH-1].row;
  assign win_col        = dly_q[DEPTH-1].col;
  assign frame_done     = frame_done_q;

endmodule

// File: tb/tb_no_border_ctrl_unit.sv
// Testbench for no_border_ctrl_unit in a 10x8 frame with a 7x7 mask and MASK_LAT=1.
// The frame-start handshake is checked cycle by cycle from a vector table.
// Whole frames are checked against a table of the 8 expected windows.
// The mid-frame sof scenario follows NO_BORDER_FRAME_CHK_EN.

module tb_no_border_ctrl_unit;

  localparam int RW = 10;
  localparam int CH = 8;
  localparam int NPIX = RW * CH;
  localparam int NWIN = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        sof;
  logic        pix_in_valid;
  logic [7:0]  pix_in;
  logic        pix_in_ready;
  logic        filt_stall;
  logic        ctrl2buf_valid;
  logic [7:0]  data_cu2bufcf;
  logic        win_valid;
  logic [15:0] win_row;
  logic [15:0] win_col;
  logic        frame_done;
  logic        frame_err;

  no_border_ctrl_unit #(
    .ROW_WIDTH (RW),
    .COL_HEIGHT(CH),
    .PIX_BIT   (8),
    .MASK_WIDTH(7),
    .MASK_LAT  (1)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .sof           (sof),
    .pix_in_valid  (pix_in_valid),
    .pix_in        (pix_in),
    .pix_in_ready  (pix_in_ready),
    .filt_stall    (filt_stall),
    .ctrl2buf_valid(ctrl2buf_valid),
    .data_cu2bufcf (data_cu2bufcf),
    .win_valid     (win_valid),
    .win_row       (win_row),
    .win_col       (win_col),
    .frame_done    (frame_done),
    .frame_err     (frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int tag;   // pixel whose ctrl2buf_valid came one cycle earlier
    int row;
    int col;
  } win_rec_t;

  typedef struct {
    logic       sof;
    logic       valid;
    logic       stall;
    logic [7:0] pix;
    logic       exp_ready;
    logic       exp_c2b;
    logic [7:0] exp_data;
    logic       exp_win;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  // Monitor state, written only by the monitor process.
  win_rec_t win_q[$];
  int       data_q[$];
  int       fd_count = 0;
  int       fd_cyc = 0;
  int       last_win_cyc = 0;
  int       cyc = 0;
  logic     prev_c2b = 1'b0;
  int       prev_data = 0;

  // Snapshots of the monitor state at the start of a frame.
  int win_base, data_base, fd_base;

  win_rec_t exp_win [NWIN];
  vec_t     vecs [7];

  // Record, at the falling edge, every window, every pixel sent to the buffers and every frame_done pulse.
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (win_valid) begin
      win_q.push_back('{prev_c2b ? prev_data : -1, int'(win_row), int'(win_col)});
      last_win_cyc <= cyc;
    end
    if (ctrl2buf_valid) data_q.push_back(int'(data_cu2bufcf));
    if (frame_done) begin
      fd_count <= fd_count + 1;
      fd_cyc   <= cyc;
    end
    prev_c2b  <= ctrl2buf_valid;
    prev_data <= int'(data_cu2bufcf);
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic mark();
    win_base  = win_q.size();
    data_base = data_q.size();
    fd_base   = fd_count;
  endtask

  task automatic pulse_sof();
    sof = 1'b1;
    @(posedge clk); #1;
    sof = 1'b0;
  endtask

  // Offer pixels first..last and retry each one until it is accepted.
  // A gap_pct share of the cycles have no valid pixel. A 5-cycle filt_stall
  // is applied just before the pixel stall_at.
  task automatic drive(input int first, input int last, input int gap_pct, input int stall_at);
    int  i;
    int  budget;
    bit  acc;
    bit  stalled;
    i = first; budget = 0; stalled = 0;
    while (i <= last && budget < 4000) begin
      if (i == stall_at && !stalled) begin
        stalled      = 1;
        pix_in       = 8'(i);
        pix_in_valid = 1'b1;
        filt_stall   = 1'b1;
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          check($sformatf("stall_ready_%0d", k), int'(pix_in_ready), 0);
          if (k > 0) check($sformatf("stall_c2b_%0d", k), int'(ctrl2buf_valid), 0);
          @(posedge clk); #1;
          budget++;
        end
        filt_stall = 1'b0;
      end
      pix_in       = 8'(i);
      pix_in_valid = (gap_pct == 0) || (int'($urandom_range(99)) >= gap_pct);
      @(negedge clk);
      acc = pix_in_valid & pix_in_ready;
      @(posedge clk); #1;
      if (acc) i++;
      budget++;
    end
    pix_in_valid = 1'b0;
    check("drive_done", i, last + 1);
  endtask

  // Wait, with a bound, for frame_done, then allow a few cycles for a spurious second pulse.
  task automatic wait_frame();
    int n;
    n = 0;
    while (fd_count == fd_base && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (4) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic check_frame(input string tag);
    int nw;
    int errs;
    nw = win_q.size() - win_base;
    check({tag, "_win_count"}, nw, NWIN);
    for (int k = 0; k < NWIN; k++) begin
      if (k < nw) begin
        check($sformatf("%s_win%0d_pix", tag, k), win_q[win_base+k].tag, exp_win[k].tag);
        check($sformatf("%s_win%0d_row", tag, k), win_q[win_base+k].row, exp_win[k].row);
        check($sformatf("%s_win%0d_col", tag, k), win_q[win_base+k].col, exp_win[k].col);
      end
    end
    errs = 0;
    for (int k = data_base; k < data_q.size(); k++) begin
      if (data_q[k] != k - data_base) errs++;
    end
    check({tag, "_data_count"}, data_q.size() - data_base, NPIX);
    check({tag, "_data_order_errs"}, errs, 0);
    check({tag, "_frame_done_count"}, fd_count - fd_base, 1);
    check({tag, "_frame_done_gap"}, fd_cyc - last_win_cyc, 1);
    // Back in IDLE: an offered pixel is refused and not passed on.
    pix_in_valid = 1'b1;
    @(negedge clk);
    check({tag, "_idle_ready"}, int'(pix_in_ready), 0);
    @(posedge clk); #1;
    pix_in_valid = 1'b0;
    @(negedge clk);
    check({tag, "_idle_c2b"}, int'(ctrl2buf_valid), 0);
    @(posedge clk); #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, int'(pix_in_ready), 0);
    check({tag, "_c2b"}, int'(ctrl2buf_valid), 0);
    check({tag, "_data"}, int'(data_cu2bufcf), 0);
    check({tag, "_win_valid"}, int'(win_valid), 0);
    check({tag, "_win_row"}, int'(win_row), 0);
    check({tag, "_win_col"}, int'(win_col), 0);
    check({tag, "_frame_done"}, int'(frame_done), 0);
    check({tag, "_frame_err"}, int'(frame_err), 0);
  endtask

  initial begin
    // Windows in a 10x8 frame: bottom-right corners at rows 6..7, cols 6..9.
    exp_win[0] = '{66, 3, 3};
    exp_win[1] = '{67, 3, 4};
    exp_win[2] = '{68, 3, 5};
    exp_win[3] = '{69, 3, 6};
    exp_win[4] = '{76, 4, 3};
    exp_win[5] = '{77, 4, 4};
    exp_win[6] = '{78, 4, 5};
    exp_win[7] = '{79, 4, 6};

    // Frame start cycle by cycle: the sof cycle refuses, then latency 1, a gap, a stall and data hold.
    //          sof   vld   stl   pix    rdy   c2b   data   win
    vecs[0] = '{1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 8'd0, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 8'd1, 1'b1, 1'b1, 8'd0, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 1'b0, 8'd2, 1'b1, 1'b1, 8'd1, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 1'b1, 8'd2, 1'b0, 1'b0, 8'd1, 1'b0};
    vecs[5] = '{1'b0, 1'b1, 1'b0, 8'd2, 1'b1, 1'b0, 8'd1, 1'b0};
    vecs[6] = '{1'b0, 1'b0, 1'b0, 8'd3, 1'b1, 1'b1, 8'd2, 1'b0};

    reset = 1'b1; sof = 1'b0; pix_in_valid = 1'b0; pix_in = '0; filt_stall = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset = 1'b0;
    @(posedge clk); #1;

    // Frame 1: the vector-table prefix, then the rest with no gaps.
    mark();
    for (int v = 0; v < 7; v++) begin
      sof = vecs[v].sof; pix_in_valid = vecs[v].valid;
      filt_stall = vecs[v].stall; pix_in = vecs[v].pix;
      @(negedge clk);
      check($sformatf("vec%0d_ready", v), int'(pix_in_ready), int'(vecs[v].exp_ready));
      check($sformatf("vec%0d_c2b", v), int'(ctrl2buf_valid), int'(vecs[v].exp_c2b));
      check($sformatf("vec%0d_data", v), int'(data_cu2bufcf), int'(vecs[v].exp_data));
      check($sformatf("vec%0d_win", v), int'(win_valid), int'(vecs[v].exp_win));
      @(posedge clk); #1;
    end
    sof = 1'b0; filt_stall = 1'b0;
    drive(3, NPIX - 1, 0, -1);
    wait_frame();
    check_frame("plain");

    // Frame 2: a 5-cycle stall in the middle of row 4.
    mark();
    pulse_sof();
    drive(0, NPIX - 1, 0, 45);
    wait_frame();
    check_frame("stall");

    // Frame 3: valid is low about half of the time.
    mark();
    pulse_sof();
    drive(0, NPIX - 1, 50, -1);
    wait_frame();
    check_frame("gaps");

    // Frame 4: reset after pixel 40, then a clean frame.
    pulse_sof();
    drive(0, 40, 0, -1);
    reset = 1'b1;
    #1;
    check_all_zero("midreset");
    @(posedge clk); #1;
    reset = 1'b0;
    mark();
    pix_in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("post_reset_ready", int'(pix_in_ready), 0);
      @(posedge clk); #1;
    end
    pix_in_valid = 1'b0;
    check("post_reset_no_fd", fd_count - fd_base, 0);
    pulse_sof();
    drive(0, NPIX - 1, 0, -1);
    wait_frame();
    check_frame("after_reset");

`ifdef NO_BORDER_FRAME_CHK_EN
    // Frame 5: a sof after pixel 50 restarts the frame and sets the sticky error.
    pulse_sof();
    drive(0, 50, 0, -1);
    sof = 1'b1; pix_in_valid = 1'b1; pix_in = 8'd51;
    @(negedge clk);
    check("restart_ready", int'(pix_in_ready), 0);
    @(posedge clk); #1;
    sof = 1'b0; pix_in_valid = 1'b0;
    check("restart_err", int'(frame_err), 1);
    mark();
    drive(0, NPIX - 1, 0, -1);
    wait_frame();
    check_frame("restart");
    check("restart_err_sticky", int'(frame_err), 1);
`else
    // Frame 5: a sof in the middle of the frame is ignored.
    mark();
    pulse_sof();
    drive(0, 44, 0, -1);
    pulse_sof();
    drive(45, NPIX - 1, 0, -1);
    wait_frame();
    check_frame("midsof");
    check("midsof_err", int'(frame_err), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
